// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: shared constants, coin FSM states and the rotation helper for arcade_input_mapper
package arcade_input_pkg;
  localparam int JB_RIGHT = 0;
  localparam int JB_FIRE = 4;
  localparam int JB_START1 = 5;
  localparam int JB_START2 = 6;
  localparam int JB_COIN = 7;
  localparam int JB_FIRE2 = 8;
  localparam int P_RIGHT = 0;
  localparam int P_UP = 3;
  localparam int P_FIRE = 4;
  localparam int P_FIRE2 = 5;
  localparam int K_RIGHT1 = 0;
  localparam int K_LEFT1 = 1;
  localparam int K_DOWN1 = 2;
  localparam int K_UP1 = 3;
  localparam int K_FIRE1 = 4;
  localparam int K_FIRE2_1 = 5;
  localparam int K_START1 = 6;
  localparam int K_START2 = 7;
  localparam int K_COIN1 = 8;
  localparam int K_COIN2 = 9;
  localparam int K_RIGHT2 = 10;
  localparam int K_LEFT2 = 11;
  localparam int K_DOWN2 = 12;
  localparam int K_UP2 = 13;
  localparam int K_FIRE_2 = 14;
  localparam int K_FIRE2_2 = 15;
  localparam int K_SERVICE = 16;
  localparam int NKEYS = 17;
  localparam logic [7:0] SC_UP = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;
  localparam logic [7:0] SC_LEFT = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_LCTRL = 8'h14;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ALT = 8'h11;
  localparam logic [7:0] SC_F1 = 8'h05;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_F2 = 8'h06;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  typedef enum logic [1:0] {ROT_0, ROT_CW, ROT_180, ROT_CCW} rot_e;
  typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_WAIT} coin_state_e;
  // d = {up, down, left, right}; result is game direction from physical direction
  function automatic logic [3:0] rotate_dirs(input logic [3:0] d, input rot_e r);
    return r == ROT_CW  ? {d[1], d[0], d[2], d[3]} :
           r == ROT_180 ? {d[2], d[3], d[0], d[1]} :
           r == ROT_CCW ? {d[0], d[1], d[3], d[2]} : d;
  endfunction
endpackage

// File: rtl/arcade_input_mapper_coin_shaper.sv
// coin_shaper: turns a raw coin level into one fixed-width credit pulse with release holdoff
// ports: clk_sys, RESET_N (async active-low), raw (merged coin level), coin (registered pulse)
module coin_shaper
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_CYCLES = 16'd12000,
  parameter logic [15:0] COIN_HOLDOFF = 16'd60000
) (
  input  logic clk_sys,
  input  logic RESET_N,
  input  logic raw,
  output logic coin
);
  coin_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic raw_q, coin_q, coin_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      COIN_IDLE: if (raw && !raw_q) begin
        state_d = COIN_PULSE;
        cnt_d = '0;
      end
      COIN_PULSE: if (cnt_q == COIN_CYCLES - 16'd1) begin
        state_d = COIN_WAIT;
        cnt_d = '0;
      end else cnt_d = cnt_q + 16'd1;
      COIN_WAIT: if (raw) cnt_d = '0;
      else if (cnt_q == COIN_HOLDOFF - 16'd1) begin
        state_d = COIN_IDLE;
        cnt_d = '0;
      end else cnt_d = cnt_q + 16'd1;
      default: begin
        state_d = COIN_IDLE;
        cnt_d = '0;
      end
    endcase
    coin_d = state_d == COIN_PULSE;
  end
  always_ff @(posedge clk_sys or negedge RESET_N)
    if (!RESET_N) begin
      state_q <= COIN_IDLE;
      cnt_q <= '0;
      raw_q <= 1'b0;
      coin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      raw_q <= raw;
      coin_q <= coin_d;
    end
  assign coin = coin_q;
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2 key decode + joystick merge, rotation/cocktail, autofire and coin shaping
// in: clk_sys, RESET_N, ps2_key, joystick_0/1, rotate, cocktail, autofire_en
// out (registered): p1/p2 {fire2,fire,up,down,left,right}, start1/2, coin1/2, service
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter bit JOY_MERGE = 1'b1,
  parameter logic [15:0] COIN_CYCLES = 16'd12000,
  parameter logic [15:0] COIN_HOLDOFF = 16'd60000,
  parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic [1:0]  rotate,
  input  logic        cocktail,
  input  logic        autofire_en,
  output logic [5:0]  p1,
  output logic [5:0]  p2,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        coin2,
  output logic        service
);
  logic tog_q, armed_q, evt, phase_q, phase_d, af_wrap;
  logic [NKEYS-1:0] key_q, key_d, hit;
  logic [8:0] j0_q, j1_q;
  logic [19:0] af_cnt_q, af_cnt_d;
  logic [5:0] j0v, j1v, p1_raw, p2_raw, p1_q, p1_d, p2_q, p2_d;
  logic start1_q, start1_d, start2_q, start2_d, service_q, service_d, coin1_raw, coin2_raw;
  logic [7:0] sc;
  logic ne;
  logic unused_joy_bits;
  assign unused_joy_bits = ^{joystick_0[15:9], joystick_1[15:9]};
  assign sc = ps2_key[7:0];
  assign ne = ~ps2_key[8];
  // armed_q suppresses a false event on the first cycle after reset, when tog_q is not yet valid
  assign evt = armed_q & (ps2_key[10] ^ tog_q);
  always_comb begin
    hit = '0;
    hit[K_UP1] = sc == SC_UP;
    hit[K_DOWN1] = sc == SC_DOWN;
    hit[K_LEFT1] = sc == SC_LEFT;
    hit[K_RIGHT1] = sc == SC_RIGHT;
    hit[K_FIRE1] = ne & (sc == SC_SPACE | sc == SC_LCTRL);
    hit[K_FIRE2_1] = ne & (sc == SC_ALT);
    hit[K_START1] = ne & (sc == SC_F1 | sc == SC_1);
    hit[K_START2] = ne & (sc == SC_F2 | sc == SC_2);
    hit[K_COIN1] = ne & (sc == SC_5);
    hit[K_COIN2] = ne & (sc == SC_6);
    hit[K_UP2] = ne & (sc == SC_R);
    hit[K_DOWN2] = ne & (sc == SC_F);
    hit[K_LEFT2] = ne & (sc == SC_D);
    hit[K_RIGHT2] = ne & (sc == SC_G);
    hit[K_FIRE_2] = ne & (sc == SC_A);
    hit[K_FIRE2_2] = ne & (sc == SC_S);
    hit[K_SERVICE] = ne & (sc == SC_T);
    key_d = evt ? (key_q & ~hit) | (hit & {NKEYS{ps2_key[9]}}) : key_q;
    af_wrap = af_cnt_q == AUTOFIRE_DIV - 20'd1;
    af_cnt_d = af_wrap ? '0 : af_cnt_q + 20'd1;
    phase_d = af_wrap ? ~phase_q : phase_q;
    j0v = {j0_q[JB_FIRE2], j0_q[JB_FIRE:JB_RIGHT]};
    j1v = {j1_q[JB_FIRE2], j1_q[JB_FIRE:JB_RIGHT]};
    p1_raw = key_q[K_FIRE2_1:K_RIGHT1] | j0v | (JOY_MERGE ? j1v : 6'd0);
    p2_raw = key_q[K_FIRE2_2:K_RIGHT2] | j1v | (JOY_MERGE ? j0v : 6'd0);
    p1_d = {p1_raw[P_FIRE2], p1_raw[P_FIRE] & (~autofire_en | phase_q),
            rotate_dirs(p1_raw[P_UP:P_RIGHT], rot_e'(rotate))};
    // cocktail adds a half turn for the player sitting opposite
    p2_d = {p2_raw[P_FIRE2], p2_raw[P_FIRE] & (~autofire_en | phase_q),
            rotate_dirs(p2_raw[P_UP:P_RIGHT], rot_e'(rotate + {cocktail, 1'b0}))};
    start1_d = key_q[K_START1] | j0_q[JB_START1] | (JOY_MERGE & j1_q[JB_START1]);
    start2_d = key_q[K_START2] | j1_q[JB_START2] | (JOY_MERGE & j0_q[JB_START2]);
    coin1_raw = key_q[K_COIN1] | j0_q[JB_COIN] | (JOY_MERGE & j1_q[JB_COIN]);
    coin2_raw = key_q[K_COIN2] | j1_q[JB_COIN] | (JOY_MERGE & j0_q[JB_COIN]);
    service_d = key_q[K_SERVICE];
  end
  always_ff @(posedge clk_sys or negedge RESET_N)
    if (!RESET_N) begin
      tog_q <= 1'b0;
      armed_q <= 1'b0;
      key_q <= '0;
      j0_q <= '0;
      j1_q <= '0;
      af_cnt_q <= '0;
      phase_q <= 1'b1;
      p1_q <= '0;
      p2_q <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      service_q <= 1'b0;
    end else begin
      tog_q <= ps2_key[10];
      armed_q <= 1'b1;
      key_q <= key_d;
      j0_q <= joystick_0[8:0];
      j1_q <= joystick_1[8:0];
      af_cnt_q <= af_cnt_d;
      phase_q <= phase_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
      service_q <= service_d;
    end
  coin_shaper #(.COIN_CYCLES(COIN_CYCLES), .COIN_HOLDOFF(COIN_HOLDOFF)) u_coin1 (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .raw(coin1_raw), .coin(coin1));
  coin_shaper #(.COIN_CYCLES(COIN_CYCLES), .COIN_HOLDOFF(COIN_HOLDOFF)) u_coin2 (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .raw(coin2_raw), .coin(coin2));
  assign p1 = p1_q;
  assign p2 = p2_q;
  assign start1 = start1_q;
  assign start2 = start2_q;
  assign service = service_q;
endmodule
